// File: rtl/note_judge_if.sv
// Player-facing signal bundle for note_judge: controls and chord inputs in,
// the lamp mirror, score pulses and counters out.
interface note_judge_if #(
  parameter int LANES = 5,
  parameter int CNT_W = 16
);
  logic             pause;
  logic             strum;
  logic [LANES-1:0] buttons;
  logic [LANES-1:0] exp_notes;
  logic [LANES-1:0] LEDR;
  logic             note_hit;
  logic             note_miss;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;
  logic [CNT_W-1:0] combo;

  modport master (
    output pause, strum, buttons, exp_notes,
    input  LEDR, note_hit, note_miss, hit_count, miss_count, combo
  );

  modport slave (
    input  pause, strum, buttons, exp_notes,
    output LEDR, note_hit, note_miss, hit_count, miss_count, combo
  );
endinterface

// File: rtl/note_judge.sv
// Rhythm-game note judge: captures the fret chord over a window after each
// strum and scores it against the chord window opened by the note sequencer.
module note_judge #(
  parameter int LANES          = 5,
  parameter int CAPTURE_CYCLES = 500,
  parameter int CNT_W          = 16,
  parameter int GHOST_PENALTY  = 1
) (
  input  logic         clk,
  input  logic         reset,
  note_judge_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

  localparam logic [CNT_W-1:0] CAP_END = CNT_W'(CAPTURE_CYCLES);
  localparam bit               GHOST   = (GHOST_PENALTY != 0);

  state_t           r_state;
  logic             r_strum_d;
  logic [LANES-1:0] r_key_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_key_valid;
  logic [LANES-1:0] r_exp_d;
  logic [LANES-1:0] r_win_pat;
  logic             r_win_open;
  logic             r_judged;
  logic             r_note_hit;
  logic             r_note_miss;
  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_miss_count;
  logic [CNT_W-1:0] r_combo;

  logic             w_rise;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_open;
  logic             w_close;
  logic             w_judge;
  logic             w_hit;
  logic             w_judge_miss;
  logic             w_close_miss;
  logic             w_any_miss;
  logic [1:0]       w_miss_inc;
  logic [CNT_W:0]   w_miss_sum;

  always_comb begin
    w_rise       = bus.strum & ~r_strum_d;
    w_cnt_nxt    = r_cnt + CNT_W'(1);
    w_open       = (bus.exp_notes != '0) && (bus.exp_notes != r_exp_d);
    w_close      = r_win_open && (bus.exp_notes != r_win_pat);
    // A capture completing on the closing cycle is judged against the closing
    // pattern, which also suppresses that window's unjudged-close miss.
    w_judge      = r_key_valid && r_win_open && !r_judged;
    w_hit        = w_judge && (r_key_acc == r_win_pat);
    w_judge_miss = (w_judge && !w_hit) || (r_key_valid && !w_judge && GHOST);
    w_close_miss = w_close && !r_judged && !w_judge;
    w_miss_inc   = {1'b0, w_judge_miss} + {1'b0, w_close_miss};
    w_any_miss   = (w_miss_inc != 2'd0);
    w_miss_sum   = {1'b0, r_miss_count} + (CNT_W+1)'(w_miss_inc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_strum_d    <= 1'b0;
      r_key_acc    <= '0;
      r_cnt        <= '0;
      r_key_valid  <= 1'b0;
      r_exp_d      <= '0;
      r_win_pat    <= '0;
      r_win_open   <= 1'b0;
      r_judged     <= 1'b0;
      r_note_hit   <= 1'b0;
      r_note_miss  <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_combo      <= '0;
    end else if (bus.pause) begin
      r_note_hit  <= 1'b0;
      r_note_miss <= 1'b0;
    end else begin
      r_strum_d   <= bus.strum;
      r_exp_d     <= bus.exp_notes;
      r_key_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_key_acc <= bus.buttons;
            r_cnt     <= CNT_W'(1);
            if (CAP_END == CNT_W'(1)) begin
              r_key_valid <= 1'b1;
              r_state     <= HOLD;
            end else begin
              r_state <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          r_key_acc <= r_key_acc | bus.buttons;
          r_cnt     <= w_cnt_nxt;
          if (w_cnt_nxt == CAP_END) begin
            r_key_valid <= 1'b1;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          if (!bus.strum) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // A new window opening on the same cycle the old one closes starts fresh.
      if (w_open) begin
        r_win_open <= 1'b1;
        r_win_pat  <= bus.exp_notes;
        r_judged   <= 1'b0;
      end else begin
        if (w_close) r_win_open <= 1'b0;
        if (w_judge) r_judged   <= 1'b1;
      end

      r_note_hit  <= w_hit && !w_any_miss;
      r_note_miss <= w_any_miss;

      if (w_hit && (r_hit_count != '1)) r_hit_count <= r_hit_count + CNT_W'(1);

      if (w_any_miss)                     r_combo <= '0;
      else if (w_hit && (r_combo != '1)) r_combo <= r_combo + CNT_W'(1);

      if (w_miss_sum[CNT_W]) r_miss_count <= '1;
      else                   r_miss_count <= w_miss_sum[CNT_W-1:0];
    end
  end

  assign bus.LEDR       = bus.exp_notes;
  assign bus.note_hit   = r_note_hit & ~bus.pause;
  assign bus.note_miss  = r_note_miss & ~bus.pause;
  assign bus.hit_count  = r_hit_count;
  assign bus.miss_count = r_miss_count;
  assign bus.combo      = r_combo;

endmodule
